// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM state encoding and helpers shared by the UART receive and transmit paths
//   No ports. Provides:
//     DEF_CLK_FREQ, DEF_BAUD, DEF_OVERSAMPLE  default clock rate, line rate and samples per bit
//     MID_LO, MID_HI                          first and last mid-bit sample ticks used for voting
//     uartState_t                             receiver FSM state encoding
//     majority3()                             2-of-3 vote
package uart_pkg;
    localparam int DEF_CLK_FREQ   = 100_000_000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int MID_LO         = 7;
    localparam int MID_HI         = 9;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uartState_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: received-byte handshake and status between the UART receiver and its consumer
//   rx_data[7:0]  last received byte                     receiver -> consumer
//   rx_valid      byte available, held until rx_ack      receiver -> consumer
//   rx_overrun    sticky, a byte was overwritten unread  receiver -> consumer
//   rx_frame_err  one-cycle pulse, stop bit was low      receiver -> consumer
//   rx_busy       a frame is being received              receiver -> consumer
//   rx_ack        one-cycle pulse, rx_data was taken     consumer -> receiver
interface uart_rx_deserializer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;
    logic       rx_ack;

    modport master (output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy, input rx_ack);
    modport slave  (input rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy, output rx_ack);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling prescaler, one-cycle tick every DIV clocks
//   pClk     in   system clock, rising edge
//   pReset   in   asynchronous active-low reset
//   restart  in   realign: count returns to 0 on the next clock
//   tick     out  high while the count sits at DIV-1
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = DEF_CLK_FREQ / (DEF_BAUD * DEF_OVERSAMPLE)
)(
    input  logic pClk,
    input  logic pReset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge pClk or negedge pReset)
        if (!pReset)
            cnt <= '0;
        else
            cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling 8N1 UART receiver with valid/ack byte handshake and error status
//   pClk    in   system clock, rising edge
//   pReset  in   asynchronous active-low reset
//   RxD     in   serial line, idle high, asynchronous to pClk
//   rxIf    master side of uart_rx_deserializer_if:
//           rx_data/rx_valid/rx_overrun/rx_frame_err/rx_busy out, rx_ack in
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
)(
    input logic pClk,
    input logic pReset,
    input logic RxD,
    uart_rx_deserializer_if.master rxIf
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);

    uartState_t state, nextState;

    // [1:0] is the synchronizer, [2] holds the previous synced value for falling-edge detection
    logic [2:0]    rxSync;
    logic          rxIn, rxFall;
    logic          tick, decide, maj;
    logic          restart, shiftEn, byteDone, frameErr, busy;
    logic [SW-1:0] sampleCnt;
    logic [2:0]    bitCnt;
    logic          voteLo, voteMid;
    logic [7:0]    shreg;
    logic [7:0]    dataQ;
    logic          validQ, overrunQ, frameErrQ;

    assign rxIn   = rxSync[1];
    assign rxFall = rxSync[2] & ~rxSync[1];
    assign decide = tick && (sampleCnt == SW'(MID_HI));
    assign maj    = majority3(voteLo, voteMid, rxIn);

    always_ff @(posedge pClk or negedge pReset)
        if (!pReset)
            rxSync <= 3'b111;
        else
            rxSync <= {rxSync[1:0], RxD};

    uart_baud_tick #(.DIV(DIV)) baudTick (
        .pClk    (pClk),
        .pReset  (pReset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge pClk or negedge pReset)
        if (!pReset)
            state <= IDLE;
        else
            state <= nextState;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = rxFall ? START : IDLE;
            START:   nextState = decide ? (maj ? IDLE : DATA) : START;
            DATA:    nextState = (decide && bitCnt == 3'd7) ? STOP : DATA;
            STOP:    nextState = decide ? (maj ? IDLE : BREAK) : STOP;
            BREAK:   nextState = rxIn ? IDLE : BREAK;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        restart  = (state == IDLE) && rxFall;
        shiftEn  = (state == DATA) && decide;
        byteDone = (state == STOP) && decide && maj;
        frameErr = (state == STOP) && decide && !maj;
        busy     = (state != IDLE);
    end

    // sample ticks are counted from the start edge so ticks MID_LO..MID_HI straddle mid-bit
    always_ff @(posedge pClk or negedge pReset)
        if (!pReset) begin
            sampleCnt <= '0;
            bitCnt    <= '0;
            voteLo    <= 1'b0;
            voteMid   <= 1'b0;
            shreg     <= '0;
        end else begin
            if (restart)
                sampleCnt <= '0;
            else if (tick && busy)
                sampleCnt <= (sampleCnt == SW'(OVERSAMPLE - 1)) ? '0 : sampleCnt + 1'b1;
            if (restart)
                bitCnt <= '0;
            else if (shiftEn)
                bitCnt <= bitCnt + 1'b1;
            if (tick && sampleCnt == SW'(MID_LO))
                voteLo <= rxIn;
            if (tick && sampleCnt == SW'(MID_LO + 1))
                voteMid <= rxIn;
            if (shiftEn)
                shreg <= {maj, shreg[7:1]};
        end

    // an ack that coincides with a new byte is consumed by that byte and leaves overrun as it was
    always_ff @(posedge pClk or negedge pReset)
        if (!pReset) begin
            dataQ     <= '0;
            validQ    <= 1'b0;
            overrunQ  <= 1'b0;
            frameErrQ <= 1'b0;
        end else begin
            frameErrQ <= frameErr;
            if (byteDone) begin
                dataQ    <= shreg;
                validQ   <= 1'b1;
                overrunQ <= overrunQ | (validQ & ~rxIf.rx_ack);
            end else if (rxIf.rx_ack && validQ) begin
                validQ   <= 1'b0;
                overrunQ <= 1'b0;
            end
        end

    assign rxIf.rx_data      = dataQ;
    assign rxIf.rx_valid     = validQ;
    assign rxIf.rx_overrun   = overrunQ;
    assign rxIf.rx_frame_err = frameErrQ;
    assign rxIf.rx_busy      = busy;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: scoreboard bench for uart_rx_deserializer with a scaled-down baud divider
module tb_uart_rx_deserializer;
    localparam int CLK_FREQ   = 614_400;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int BIT        = DIV * OVERSAMPLE;
    // clocks from the first low RxD sample to the cycle whose edge completes the byte:
    // two synchronizer stages, then tick 9 of the stop bit (bit 9), counted from the start edge
    localparam int DONE_CYC   = 2 + (9 * OVERSAMPLE + 9 + 1) * DIV;

    typedef struct packed {
        logic [7:0] d;
        logic       ov;
    } exp_t;

    logic pClk = 0;
    logic pReset = 1;
    logic RxD = 1;

    uart_rx_deserializer_if rxIf();

    uart_rx_deserializer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .pClk   (pClk),
        .pReset (pReset),
        .RxD    (RxD),
        .rxIf   (rxIf)
    );

    always #5 pClk = ~pClk;

    int total = 0;
    int bad = 0;
    int feCnt = 0;
    int expFe = 0;
    int busyRun = 0;
    int lastBusyLen = 0;
    logic done = 0;
    exp_t expQ[$];
    exp_t e;
    logic mValid = 0, mBusy = 0, mFe = 0;
    logic [7:0] mData = 0;
    logic [7:0] rByte;
    int rLen, rGap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic sendBit(input logic b, input int len);
        RxD = b;
        repeat (len) @(negedge pClk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input int len, input logic stopv);
        sendBit(1'b0, len);
        for (int i = 0; i < 8; i++) sendBit(d[i], len);
        sendBit(stopv, len);
    endtask

    task automatic push(input logic [7:0] d, input logic ov);
        expQ.push_back('{d: d, ov: ov});
    endtask

    task automatic drain();
        int t = 0;
        while (expQ.size() != 0 && t < 3000) begin
            @(negedge pClk);
            t++;
        end
        chk("drain", expQ.size(), 0);
    endtask

    task automatic ack();
        rxIf.rx_ack = 1'b1;
        @(negedge pClk);
        rxIf.rx_ack = 1'b0;
    endtask

    // monitor: every newly presented byte (valid rise or overwrite while valid) is checked against the queue
    initial forever begin
        @(negedge pClk);
        if (pReset) begin
            if (rxIf.rx_valid && (!mValid || rxIf.rx_data != mData)) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h, want none", rxIf.rx_data);
                end else begin
                    e = expQ.pop_front();
                    chk("rx_data", rxIf.rx_data, e.d);
                    chk("rx_overrun", rxIf.rx_overrun, e.ov);
                    if (!mValid) chk("busy_fall", {mBusy, rxIf.rx_busy}, 2'b10);
                end
            end
            if (rxIf.rx_frame_err) begin
                feCnt++;
                chk("fe_pulse_width", mFe, 0);
            end
            if (rxIf.rx_busy) busyRun++;
            else begin
                if (busyRun != 0) lastBusyLen = busyRun;
                busyRun = 0;
            end
        end
        mValid = rxIf.rx_valid;
        mData  = rxIf.rx_data;
        mBusy  = rxIf.rx_busy;
        mFe    = rxIf.rx_frame_err;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rxIf.rx_ack = 1'b0;
        #2 pReset = 0;
        repeat (3) @(negedge pClk);
        chk("reset_data", rxIf.rx_data, 0);
        chk("reset_valid", rxIf.rx_valid, 0);
        chk("reset_overrun", rxIf.rx_overrun, 0);
        chk("reset_fe", rxIf.rx_frame_err, 0);
        chk("reset_busy", rxIf.rx_busy, 0);
        pReset = 1;
        sendBit(1'b1, BIT);

        push(8'h14, 0);
        sendFrame(8'h14, BIT, 1'b1);
        sendBit(1'b1, BIT);
        drain();
        chk("valid_held", rxIf.rx_valid, 1);
        ack();
        chk("valid_cleared", rxIf.rx_valid, 0);
        chk("no_fe_14", feCnt, expFe);

        sendBit(1'b0, 18);
        sendBit(1'b1, 2 * BIT);
        chk("glitch_valid", rxIf.rx_valid, 0);
        chk("glitch_fe", feCnt, expFe);
        chk("glitch_idle", rxIf.rx_busy, 0);
        chk("glitch_busy_short", (lastBusyLen > 0) && (lastBusyLen < BIT), 1);

        sendFrame(8'hA5, BIT, 1'b0);
        sendBit(1'b0, 2 * BIT);
        sendBit(1'b1, BIT);
        expFe++;
        chk("fe_count", feCnt, expFe);
        chk("fe_no_valid", rxIf.rx_valid, 0);
        push(8'h3C, 0);
        sendFrame(8'h3C, BIT, 1'b1);
        sendBit(1'b1, BIT);
        drain();
        ack();

        push(8'h11, 0);
        sendFrame(8'h11, BIT, 1'b1);
        sendBit(1'b1, BIT);
        push(8'h22, 1);
        sendFrame(8'h22, BIT, 1'b1);
        sendBit(1'b1, BIT);
        drain();
        chk("ovr_data", rxIf.rx_data, 8'h22);
        chk("ovr_valid", rxIf.rx_valid, 1);
        chk("ovr_flag", rxIf.rx_overrun, 1);
        ack();
        chk("ovr_valid_clr", rxIf.rx_valid, 0);
        chk("ovr_flag_clr", rxIf.rx_overrun, 0);

        push(8'h33, 0);
        sendFrame(8'h33, BIT, 1'b1);
        sendBit(1'b1, BIT);
        push(8'h44, 0);
        fork
            sendFrame(8'h44, BIT, 1'b1);
            begin
                repeat (DONE_CYC) @(negedge pClk);
                ack();
            end
        join
        sendBit(1'b1, BIT);
        drain();
        chk("sim_valid", rxIf.rx_valid, 1);
        chk("sim_data", rxIf.rx_data, 8'h44);
        chk("sim_overrun", rxIf.rx_overrun, 0);
        ack();

        sendBit(1'b0, BIT);
        sendBit(1'b1, BIT);
        sendBit(1'b1, BIT);
        sendBit(1'b1, BIT / 2);
        pReset = 0;
        #1;
        chk("mid_reset_data", rxIf.rx_data, 0);
        chk("mid_reset_valid", rxIf.rx_valid, 0);
        chk("mid_reset_overrun", rxIf.rx_overrun, 0);
        chk("mid_reset_fe", rxIf.rx_frame_err, 0);
        chk("mid_reset_busy", rxIf.rx_busy, 0);
        repeat (3) @(negedge pClk);
        RxD = 1;
        pReset = 1;
        sendBit(1'b1, 2 * BIT);
        push(8'h5A, 0);
        sendFrame(8'h5A, BIT, 1'b1);
        sendBit(1'b1, BIT);
        drain();
        chk("post_reset_overrun", rxIf.rx_overrun, 0);
        chk("post_reset_fe", feCnt, expFe);
        ack();

        push(8'h14, 0);
        sendFrame(8'h14, BIT - 1, 1'b1);
        sendBit(1'b1, BIT);
        drain();
        ack();
        push(8'h14, 0);
        sendFrame(8'h14, BIT + 1, 1'b1);
        sendBit(1'b1, BIT);
        drain();
        ack();

        fork
            begin
                for (int n = 0; n < 16; n++) begin
                    rGap  = $urandom_range(0, 2);
                    rLen  = $urandom_range(BIT - 1, BIT + 1);
                    rByte = 8'($urandom);
                    sendBit(1'b1, rGap * BIT);
                    push(rByte, 0);
                    sendFrame(rByte, rLen, 1'b1);
                end
                sendBit(1'b1, BIT);
                drain();
                repeat (8) @(negedge pClk);
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge pClk);
                    if (rxIf.rx_valid && !rxIf.rx_ack) begin
                        repeat ($urandom_range(0, 3)) @(negedge pClk);
                        ack();
                    end
                end
            end
        join
        chk("rand_valid_clr", rxIf.rx_valid, 0);
        chk("final_fe", feCnt, expFe);
        chk("final_queue", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
